// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_controller
//  Purpose  : Sequencer for a 16-bit subtractive GCD datapath, with a
//             start/busy/done/err handshake and an iteration watchdog.
//             Optional macro GCD_ITER_CNT_EN exposes the step count (iter_cnt).
//  Revision : 1.0  initial release
// ============================================================================
module gcd_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             need_a,
    output logic             need_b,
    output logic             busy,
    output logic             done,
`ifdef GCD_ITER_CNT_EN
    output logic [CNT_W-1:0] iter_cnt,
`endif
    output logic             err
);

    localparam logic [CNT_W-1:0] C_MAX_ITER = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CALC   = 3'd3,
        S_SUB_A  = 3'd4,
        S_SUB_B  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_abort;
    logic             w_accept;
    logic [CNT_W-1:0] r_cnt;

    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_A;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_CALC;
            S_CALC: begin
                // Equality wins over the watchdog so a result found on the
                // last permitted step is still reported as good.
                if (eq) begin
                    w_next = S_DONE;
                end else if (r_cnt == C_MAX_ITER) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (gt) begin
                    w_next = S_SUB_A;
                end else if (lt) begin
                    w_next = S_SUB_B;
                end else begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            S_SUB_A:  w_next = S_CALC;
            S_SUB_B:  w_next = S_CALC;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            err     <= 1'b0;
            ldA     <= 1'b0;
            ldB     <= 1'b0;
            sel1    <= 1'b0;
            sel2    <= 1'b0;
            sel_in  <= 1'b0;
            need_a  <= 1'b0;
            need_b  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            ldA     <= (w_next == S_LOAD_A) || (w_next == S_SUB_A);
            ldB     <= (w_next == S_LOAD_B) || (w_next == S_SUB_B);
            sel1    <= (w_next == S_SUB_B);
            sel2    <= (w_next == S_SUB_A);
            sel_in  <= (w_next == S_LOAD_A) || (w_next == S_LOAD_B);
            need_a  <= (w_next == S_LOAD_A);
            need_b  <= (w_next == S_LOAD_B);
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);

            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == S_SUB_A) || (r_state == S_SUB_B)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                err <= 1'b0;
            end else if (w_abort) begin
                err <= 1'b1;
            end
        end
    end

`ifdef GCD_ITER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if ((r_state == S_CALC) && (w_next == S_DONE)) begin
            iter_cnt <= r_cnt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_controller
//  Purpose  : Directed plus random checks of gcd_controller driving a
//             behavioural 16-bit subtractive datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_controller;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        gt, lt, eq;
    logic        ldA, ldB, sel1, sel2, sel_in, need_a, need_b, busy, done, err;
    logic [CNT_W-1:0] iter_cnt_w;

    logic [15:0] op_a = '0, op_b = '0;
    logic [15:0] ra = '0, rb = '0;
    logic [15:0] data_in, sub_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .gt(gt), .lt(lt), .eq(eq),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .need_a(need_a), .need_b(need_b), .busy(busy), .done(done),
`ifdef GCD_ITER_CNT_EN
        .iter_cnt(iter_cnt_w),
`endif
        .err(err)
    );

`ifndef GCD_ITER_CNT_EN
    assign iter_cnt_w = '0;
`endif

    // Behavioural datapath the controller sequences.
    assign data_in = need_a ? op_a : op_b;
    assign sub_out = (sel1 ? rb : ra) - (sel2 ? rb : ra);
    assign gt = (ra > rb);
    assign lt = (ra < rb);
    assign eq = (ra == rb);

    always @(posedge clk) begin
        if (ldA) ra <= sel_in ? data_in : sub_out;
        if (ldB) rb <= sel_in ? data_in : sub_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: Euclid by subtraction, abandoned after MAX_ITER steps.
    task automatic ref_gcd(input int a_in, input int b_in,
                           output int n, output int a_out, output bit abort);
        int a = a_in;
        int b = b_in;
        n = 0;
        abort = 1'b0;
        while (a != b) begin
            if (n == MAX_ITER) begin
                abort = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        a_out = a;
    endtask

    // One operation: start is driven during cycle 0; returns after sampling done.
    task automatic run_op(input int a, input int b, input bit pulses, input bit hold);
        int n, res, done_cyc;
        bit abort;
        ref_gcd(a, b, n, res, abort);
        op_a = 16'(a);
        op_b = 16'(b);
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 4 + 2 * MAX_ITER + 10; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start = hold || (pulses && (cyc == 5 || cyc == 12));
            if (cyc == 1) check("load_a", {ldA, sel_in, need_a, need_b, ldB}, 5'b11100);
            if (cyc == 2) check("load_b", {ldB, sel_in, need_b, need_a, ldA}, 5'b11100);
            if (cyc == 3) check("calc_idle", {ldA, ldB, sel_in}, 3'b000);
            if (cyc == 1) check("err_cleared", err, 1'b0);
            check("busy", busy, 1'b1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_cycle", done_cyc, 4 + 2 * n);
        check("err", err, abort);
        check("result_a", ra, res);
        if (!abort) check("result_b", rb, res);
`ifdef GCD_ITER_CNT_EN
        check("iter_cnt", iter_cnt_w, n);
`endif
    endtask

    initial begin
        int n, res;
        bit abort;

        // Reset state
        #2;
        check("reset_outs", {ldA, ldB, sel1, sel2, sel_in, need_a, need_b, busy, done, err}, 10'd0);
        check("reset_iter", iter_cnt_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // 48/18 with start pulses mid-operation and during DONE
        run_op(48, 18, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("pulse_ignored_idle", busy, 1'b0);
        @(negedge clk);
        check("stay_idle", {busy, need_a}, 2'b00);

        run_op(7, 7, 1'b0, 1'b0);
        start = 1'b0;
        run_op(1, 10, 1'b0, 1'b0);
        start = 1'b0;

        // Zero operand: watchdog abort, err held until next start
        run_op(0, 5, 1'b0, 1'b0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("err_held", {err, busy, done}, 3'b100);
        run_op(20, 0, 1'b0, 1'b0);
        start = 1'b0;
        run_op(9, 6, 1'b0, 1'b0);
        start = 1'b0;

        // Asynchronous reset during the second SUB_A of 48/18
        op_a = 16'd48;
        op_b = 16'd18;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_sub_a", {ldA, sel2, sel1, sel_in}, 4'b1100);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", {ldA, ldB, sel1, sel2, sel_in, need_a, need_b, busy, done, err}, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(21, 14, 1'b0, 1'b0);
        start = 1'b0;

        // start held high: next LOAD_A two cycles after done
        run_op(48, 18, 1'b0, 1'b1);
        op_a = 16'd15;
        op_b = 16'd10;
        @(negedge clk);
        check("hold_idle", busy, 1'b0);
        @(negedge clk);
        check("hold_load_a", {need_a, ldA}, 2'b11);
        start = 1'b0;
        begin
            int cnt = 0;
            ref_gcd(15, 10, n, res, abort);
            while (!done && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            check("hold_second_done", done, 1'b1);
            check("hold_second_res", ra, res);
        end

        // Random operands against the reference
        for (int i = 0; i < 10; i++) begin
            run_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0, 1'b0);
            start = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
